// File: rtl/cdf_lut_builder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdf_lut_builder                                              |
// | Description : Builds the 256-entry histogram-equalisation LUT of a tile    |
// |               from its histogram: CDF accumulator + 19-cycle divider.      |
// |               Optional macro LUT_ROUND_EN selects round-half-up entries.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdf_lut_builder #(
    parameter int PIXELS = 2025
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cdf_start,
    input  logic [11*256-1:0] Count,
    output logic             lut_done,
    output logic [8*256-1:0] Lut
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_ACC      = 2'd1;
    localparam logic [1:0]  c_DIV      = 2'd2;
    localparam logic [1:0]  c_DONE     = 2'd3;
    localparam logic [10:0] c_PIXELS   = 11'(PIXELS);
    localparam logic [4:0]  c_DIV_LAST = 5'd18;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [7:0]        r_k;
    logic [11:0]       r_cdf;
    logic [11:0]       r_cdf_min;
    logic              r_min_found;
    logic [18:0]       r_num;
    logic [10:0]       r_rem;
    logic [17:0]       r_quo;
    logic [10:0]       r_den;
    logic [4:0]        r_iter;
    logic [8*256-1:0]  r_lut;
    logic              r_lut_done;

    logic              w_start_acc;
    logic              w_acc;
    logic              w_div;
    logic              w_div_last;

    logic [11:0]       w_bin_base;
    logic [10:0]       w_lut_base;
    logic [10:0]       w_bin;
    logic [11:0]       w_cdf_new;
    logic [11:0]       w_cdf_min_new;
    logic [11:0]       w_diff;
    logic [18:0]       w_prod;
    logic [10:0]       w_den;
    logic [18:0]       w_num_load;
    logic [11:0]       w_trial;
    logic              w_ge;
    logic [10:0]       w_rem_next;
    logic [18:0]       w_quo_next;
    logic [7:0]        w_lut_val;

    assign Lut      = r_lut;
    assign lut_done = r_lut_done;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (cdf_start) begin
                    w_state_next = c_ACC;
                end
            end
            c_ACC: begin
                w_state_next = c_DIV;
            end
            c_DIV: begin
                if (r_iter == c_DIV_LAST) begin
                    w_state_next = (r_k == 8'hFF) ? c_DONE : c_ACC;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ---------------- state decode ----------------
    always_comb begin
        w_start_acc = 1'b0;
        w_acc       = 1'b0;
        w_div       = 1'b0;
        w_div_last  = 1'b0;
        case (r_state)
            c_IDLE, c_DONE: w_start_acc = cdf_start;
            c_ACC:          w_acc       = 1'b1;
            c_DIV: begin
                w_div      = 1'b1;
                w_div_last = (r_iter == c_DIV_LAST);
            end
            default: ;
        endcase
    end

    // ---------------- CDF accumulate and divider load ----------------
    assign w_bin_base    = 12'(r_k) * 12'd11;
    assign w_lut_base    = {r_k, 3'b000};
    assign w_bin         = Count[w_bin_base +: 11];
    assign w_cdf_new     = r_cdf + {1'b0, w_bin};
    assign w_cdf_min_new = (!r_min_found && (w_cdf_new != 12'd0)) ? w_cdf_new : r_cdf_min;
    assign w_diff        = (w_cdf_new >= w_cdf_min_new) ? (w_cdf_new - w_cdf_min_new) : 12'd0;
    assign w_prod        = {7'd0, w_diff} * 19'd255;
    assign w_den         = c_PIXELS - w_cdf_min_new[10:0];

`ifdef LUT_ROUND_EN
    assign w_num_load    = w_prod + {9'd0, w_den[10:1]};
`else
    assign w_num_load    = w_prod;
`endif

    // ---------------- restoring divider step ----------------
    assign w_trial    = {r_rem, r_num[18]};
    assign w_ge       = (w_trial >= {1'b0, r_den});
    assign w_rem_next = w_ge ? 11'(w_trial - {1'b0, r_den}) : w_trial[10:0];
    assign w_quo_next = {r_quo, w_ge};

    // A zero denominator means the whole tile sits in one bin: identity mapping.
    assign w_lut_val  = (r_den == 11'd0)        ? r_k   :
                        (|w_quo_next[18:8])      ? 8'hFF :
                                                   w_quo_next[7:0];

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= 8'd0;
            r_cdf       <= 12'd0;
            r_cdf_min   <= 12'd0;
            r_min_found <= 1'b0;
            r_num       <= 19'd0;
            r_rem       <= 11'd0;
            r_quo       <= 18'd0;
            r_den       <= 11'd0;
            r_iter      <= 5'd0;
            r_lut       <= '0;
            r_lut_done  <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_k         <= 8'd0;
                r_cdf       <= 12'd0;
                r_cdf_min   <= 12'd0;
                r_min_found <= 1'b0;
                r_lut_done  <= 1'b0;
            end
            if (w_acc) begin
                r_cdf       <= w_cdf_new;
                r_cdf_min   <= w_cdf_min_new;
                r_min_found <= r_min_found | (w_cdf_new != 12'd0);
                r_num       <= w_num_load;
                r_den       <= w_den;
                r_rem       <= 11'd0;
                r_quo       <= 18'd0;
                r_iter      <= 5'd0;
            end
            if (w_div) begin
                r_num  <= {r_num[17:0], 1'b0};
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next[17:0];
                r_iter <= r_iter + 5'd1;
                if (w_div_last) begin
                    r_lut[w_lut_base +: 8] <= w_lut_val;
                    if (r_k == 8'hFF) begin
                        r_lut_done <= 1'b1;
                    end else begin
                        r_k <= r_k + 8'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdf_lut_builder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cdf_lut_builder                                           |
// | Description : Scoreboard bench for cdf_lut_builder (honours LUT_ROUND_EN). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cdf_lut_builder;

    localparam int PIXELS = 2025;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cdf_start = 1'b1;
    logic [11*256-1:0] Count = '0;
    logic              lut_done;
    logic [8*256-1:0]  Lut;

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];
    int   hist[256];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdf_lut_builder #(.PIXELS(PIXELS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cdf_start (cdf_start),
        .Count     (Count),
        .lut_done  (lut_done),
        .Lut       (Lut)
    );

    // Edge counter plus scoreboard monitor: entry k is due 20k+20 edges after the accept edge.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checks++;
            if (Lut[e.idx*8 +: 8] !== e.val) begin
                errors++;
                $display("FAIL lut_entry idx=%0d edge=%0d got=%0d want=%0d", e.idx, cyc, Lut[e.idx*8 +: 8], e.val);
            end
            checks++;
            if (lut_done !== ((e.idx == 255) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL lut_done_timing idx=%0d got=%b want=%b", e.idx, lut_done, (e.idx == 255));
            end
        end
    end

    function automatic void load_hist();
        for (int k = 0; k < 256; k++) begin
            Count[k*11 +: 11] = 11'(hist[k]);
        end
    endfunction

    function automatic void clear_hist();
        for (int k = 0; k < 256; k++) hist[k] = 0;
    endfunction

    // Reference model: direct equalisation formula on the histogram.
    function automatic void push_expected(input int s);
        int   cdf, cmin, den, num, v;
        bit   found;
        exp_t e;
        cdf = 0; cmin = 0; found = 0;
        for (int k = 0; k < 256; k++) begin
            cdf += hist[k];
            if (!found && cdf != 0) begin
                cmin  = cdf;
                found = 1;
            end
            den = PIXELS - cmin;
            if (den == 0) begin
                v = k;
            end else begin
                num = (cdf - cmin) * 255;
`ifdef LUT_ROUND_EN
                num += den / 2;
`endif
                v = num / den;
                if (v > 255) v = 255;
            end
            e.due = s + 20*k + 20;
            e.idx = k;
            e.val = 8'(v);
            sbq.push_back(e);
        end
    endfunction

    task automatic do_start(output int s);
        @(negedge clk);
        s = cyc + 1;
        cdf_start = 1'b1;
        push_expected(s);
        @(negedge clk);
        cdf_start = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while (sbq.size() > 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        ok = (sbq.size() == 0);
        sbq.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (Lut !== '0) begin errors++; $display("FAIL reset_lut got=%h want=0", Lut); end
        checks++;
        if (lut_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", lut_done); end
        cdf_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (lut_done !== 1'b0 || Lut !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got_done=%b lut_nonzero=%b want done=0 lut=0", lut_done, (Lut != '0));
        end
    endtask

    task automatic test_single_intensity();
        int s; bit ok;
        clear_hist(); hist[0] = 2025; load_hist();
        do_start(s);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain got=timeout want=complete"); end
        checks++;
        if (Lut[77*8 +: 8] !== 8'd77 || lut_done !== 1'b1) begin
            errors++;
            $display("FAIL single_identity got=%0d done=%b want=77 done=1", Lut[77*8 +: 8], lut_done);
        end
    endtask

    task automatic test_two_level();
        int s; bit ok;
        clear_hist(); hist[10] = 1000; hist[200] = 1025; load_hist();
        do_start(s);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL two_level_drain got=timeout want=complete"); end
        checks++;
        if (Lut[199*8 +: 8] !== 8'd0 || Lut[200*8 +: 8] !== 8'd255) begin
            errors++;
            $display("FAIL two_level_edge got=%0d,%0d want=0,255", Lut[199*8 +: 8], Lut[200*8 +: 8]);
        end
    endtask

    task automatic test_rounding();
        int s; bit ok;
        logic [7:0] want1;
`ifdef LUT_ROUND_EN
        want1 = 8'd128;
`else
        want1 = 8'd127;
`endif
        clear_hist(); hist[0] = 1; hist[1] = 1012; hist[2] = 1012; load_hist();
        do_start(s);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rounding_drain got=timeout want=complete"); end
        checks++;
        if (Lut[1*8 +: 8] !== want1) begin
            errors++;
            $display("FAIL rounding_half got=%0d want=%0d", Lut[1*8 +: 8], want1);
        end
    endtask

    task automatic test_handshake();
        int s; bit ok;
        clear_hist();
        for (int k = 0; k < 45; k++) hist[k] = 45;
        load_hist();
        do_start(s);
        while (cyc < s + 99) @(negedge clk);
        cdf_start = 1'b1;
        @(negedge clk);
        cdf_start = 1'b0;
        while (cyc < s + 3999) @(negedge clk);
        cdf_start = 1'b1;
        @(negedge clk);
        cdf_start = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL handshake_drain got=timeout want=complete"); end
    endtask

    task automatic test_restart_from_done();
        int s; bit ok;
        logic [7:0] old255;
        repeat (3) @(negedge clk);
        checks++;
        if (lut_done !== 1'b1) begin errors++; $display("FAIL done_held got=%b want=1", lut_done); end
        old255 = Lut[255*8 +: 8];
        clear_hist();
        for (int i = 0; i < PIXELS; i++) hist[$urandom_range(220, 30)]++;
        load_hist();
        do_start(s);
        checks++;
        if (lut_done !== 1'b0) begin errors++; $display("FAIL restart_done_fall got=%b want=0", lut_done); end
        checks++;
        if (Lut[255*8 +: 8] !== old255) begin
            errors++;
            $display("FAIL restart_lut_kept got=%0d want=%0d", Lut[255*8 +: 8], old255);
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL restart_drain got=timeout want=complete"); end
    endtask

    task automatic test_reset_mid_build();
        int s; bit ok;
        do_start(s);
        while (cyc < s + 3000) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        #1;
        checks++;
        if (Lut !== '0 || lut_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got_done=%b lut_nonzero=%b want done=0 lut=0", lut_done, (Lut != '0));
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(s);
        drain(ok);
        checks++;
        if (!ok || lut_done !== 1'b1) begin
            errors++;
            $display("FAIL rebuild_after_reset got_ok=%b done=%b want ok=1 done=1", ok, lut_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_intensity();
        test_two_level();
        test_rounding();
        test_handshake();
        test_restart_from_done();
        test_reset_mid_build();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cdf_lut_builder.md
# cdf_lut_builder

Downstream stage of the histogram calculator in the local contrast enhancement pipeline. Consumes the 256-bin, 11-bit-per-bin tile histogram and produces the 256-entry histogram-equalisation mapping table (LUT) for that tile. The LUT is built in a single sequential pass: a cumulative distribution function (CDF) accumulator feeds a 19-iteration restoring divider. The pixel-remap stage then indexes the LUT.

## Interface
Parameters:
- PIXELS, 2025, pixels per tile (45x45); legal range 1..2047; used as the CDF total.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- cdf_start  input  1  start request; sampled only in IDLE or DONE.
- Count  input  11*256  packed histogram; bin k at [k*11 +: 11]; must be held stable from start until lut_done.
- lut_done  output  1  level-high when the LUT is valid; held until the next accepted start or reset.
- Lut  output  8*256  packed LUT; entry k at [k*8 +: 8].

## Operation
- Reset: Lut = all 0, lut_done = 0, state IDLE, bin index k = 0, cdf = 0, cdf_min = 0, min_found = 0.
- States: IDLE, ACC, DIV, DONE.
- IDLE/DONE with cdf_start=1 -> ACC:
  - clear k, cdf, cdf_min, min_found and lut_done.
  - Lut keeps its old contents until each entry is overwritten.
- ACC (1 cycle):
  - cdf <= cdf + Count[k] (12-bit accumulator).
  - If !min_found and the new cdf != 0: cdf_min <= new cdf, min_found <= 1.
  - Load numerator = (cdf_new >= cdf_min_new) ? (cdf_new - cdf_min_new)*255 : 0, plus den/2 when rounding is enabled. Numerator width is 19 bits.
  - den = PIXELS - cdf_min_new (11 bits).
  - Go to DIV.
- DIV (exactly 19 cycles): restoring division, one quotient bit per cycle, MSB first.
  - On the 19th cycle, write Lut[k] = min(quotient, 255).
  - If den == 0, write Lut[k] = k instead. This is the single-intensity tile case. The cycle count is unchanged.
  - Then: if k == 255, go to DONE and set lut_done <= 1; otherwise k <= k+1 and go to ACC.
- Bins below the first occupied bin have cdf = 0 and map to 0. The first occupied bin maps to 0. The last occupied bin onward maps to 255.
- cdf_start in ACC or DIV is ignored.
- A Count sum greater than PIXELS is outside the contract. The output is undefined, but the FSM must still finish in the normal cycle count.

## Timing
- Fixed latency, independent of data:
  - The edge that accepts cdf_start is edge 0.
  - Lut[k] is written on edge 20k+20.
  - lut_done rises on edge 5120, together with the write of Lut[255].
- Total busy time is 256 x 20 = 5120 cycles. The block accepts a new start on the cycle after lut_done is visible.
- Start accepted in DONE: lut_done falls on the accepting edge.
- rst asserted at any time: outputs return to their reset values immediately (asynchronously) and the in-progress build is aborted. No partial LUT survives.

## Configuration
- LUT_ROUND_EN defined:
  - den/2 (floor) is added to the numerator, so each entry is round-half-up of (cdf-cdf_min)*255/den.
  - Numerator maximum is 2024*255 + 1012 = 517132, which fits in 19 bits.
- LUT_ROUND_EN undefined:
  - Nothing is added; each entry is the truncated quotient.
  - Latency and interface are identical in both builds.

## Test plan
- Reset values: assert rst -> Lut = 0, lut_done = 0; cdf_start held high during reset -> no activity.
- Single intensity: Count[0] = 2025, all other bins 0, then start -> den = 0, Lut[k] = k for every k, lut_done at edge 5120.
- Two-level tile: Count[10] = 1000, Count[200] = 1025 -> cdf_min = 1000, den = 1025; Lut[0..199] = 0, Lut[200..255] = 255.
- Rounding: Count[0] = 1, Count[1] = 1012, Count[2] = 1012 -> Lut[0] = 0, Lut[2..255] = 255. Lut[1] = 128 with LUT_ROUND_EN and 127 without (exact quotient 127.5).
- Handshake:
  - Pulse cdf_start at edges 0, 100 and 4000 -> only edge 0 accepted, lut_done still rises at edge 5120.
  - Restart from DONE -> lut_done drops on the accepting edge and rises again 5120 edges later.
- Reset mid-build: rst asserted at cycle 3000 -> Lut = 0 and lut_done = 0 immediately. A fresh start after reset gives results identical to an uninterrupted run.
